shift_add_mult: RTL and testbench



---
 rtl/shift_add_mult_pkg.sv | 14 +
 rtl/shift_add_mult_cla_nbit.sv | 62 ++++++
 rtl/shift_add_mult.sv | 105 ++++++++++
 tb/tb_shift_add_mult.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/shift_add_mult_pkg.sv
// Shared definitions for the shift-and-add multiplier.
//   mul_state_t   : FSM state encoding (IDLE / RUN / DONE)
//   DEFAULT_WIDTH : default operand width; must be a multiple of 4
package shift_add_mult_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/shift_add_mult_cla_nbit.sv
// WIDTH-bit carry-lookahead adder built from cascaded 4-bit CLA slices.
// A second-level lookahead unit turns the slice group generate/propagate
// terms into the carry-in of every slice, so no carry ripples between slices.
//   a, b : addends (WIDTH bits)
//   cin  : carry-in
//   sum  : WIDTH-bit sum
//   cout : carry-out of the most significant slice
module cla_nbit #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NS = WIDTH / 4;

  logic [NS-1:0] grp_g;
  logic [NS-1:0] grp_p;
  logic [NS:0]   slice_c;
  logic          carry;

  for (genvar s = 0; s < NS; s++) begin : g_slice
    logic [3:0] gs;
    logic [3:0] ps;
    logic [3:0] c;

    assign gs = a[4*s +: 4] & b[4*s +: 4];
    assign ps = a[4*s +: 4] ^ b[4*s +: 4];

    assign c[0] = slice_c[s];
    assign c[1] = gs[0] | (ps[0] & c[0]);
    assign c[2] = gs[1] | (ps[1] & gs[0]) | (ps[1] & ps[0] & c[0]);
    assign c[3] = gs[2] | (ps[2] & gs[1]) | (ps[2] & ps[1] & gs[0])
                | (ps[2] & ps[1] & ps[0] & c[0]);

    assign sum[4*s +: 4] = ps ^ c;

    assign grp_g[s] = gs[3] | (ps[3] & gs[2]) | (ps[3] & ps[2] & gs[1])
                    | (ps[3] & ps[2] & ps[1] & gs[0]);
    assign grp_p[s] = &ps;
  end

  // Each slice carry is an independent sum-of-products over the group terms
  // and cin; the inner loop only flattens that expression.
  always_comb begin
    slice_c = '0;
    carry   = 1'b0;
    for (int s = 0; s <= NS; s++) begin
      carry = cin;
      for (int j = 0; j < s; j++) begin
        carry = grp_g[j] | (grp_p[j] & carry);
      end
      slice_c[s] = carry;
    end
  end

  assign cout = slice_c[NS];

endmodule

// File: rtl/shift_add_mult.sv
// Iterative unsigned radix-2 shift-and-add multiplier.
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset
//   start   : request a multiply; accepted in IDLE or DONE only
//   a, b    : multiplicand / multiplier, captured when start is accepted
//   busy    : high while iterating
//   done    : one-cycle pulse, product valid
//   product : 2*WIDTH-bit result, held until the next completed multiply
//
// state    | meaning
// ---------+-----------------------------------------------------------
// MUL_IDLE | waiting for start
// MUL_RUN  | one add/shift iteration per cycle, WIDTH iterations total
// MUL_DONE | product just loaded, done pulse; start may be accepted here
module shift_add_mult
  import shift_add_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mul_state_t         state;
  mul_state_t         state_nxt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic               accept;
  logic               last_iter;

  // The adder sees the upper accumulator half every cycle; only RUN uses it.
  assign addend = acc[0] ? mcand : '0;

  cla_nbit #(
    .WIDTH (WIDTH)
  ) u_cla (
    .a    (acc[2*WIDTH-1:WIDTH]),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // Shifting the carry-out in keeps the full WIDTH+1-bit partial sum.
  assign acc_nxt   = {cout, sum, acc[WIDTH-1:1]};
  assign accept    = start && ((state == MUL_IDLE) || (state == MUL_DONE));
  assign last_iter = (state == MUL_RUN) && (cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      MUL_IDLE: if (start) state_nxt = MUL_RUN;
      MUL_RUN:  if (cnt == CNT_LAST) state_nxt = MUL_DONE;
      MUL_DONE: state_nxt = start ? MUL_RUN : MUL_IDLE;
      default:  state_nxt = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MUL_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      mcand <= a;
      acc   <= {{WIDTH{1'b0}}, b};
      cnt   <= '0;
    end else if (state == MUL_RUN) begin
      acc <= acc_nxt;
      cnt <= cnt + CNT_W'(1);
      if (last_iter) begin
        product <= acc_nxt;
      end
    end
  end

  // Decoded straight from the state register: no input-to-output path,
  // and busy/done are mutually exclusive by construction.
  assign busy = (state == MUL_RUN);
  assign done = (state == MUL_DONE);

endmodule

// File: tb/tb_shift_add_mult.sv
module tb_shift_add_mult;

  localparam int W = 16;

  typedef struct {
    logic [2*W-1:0] prod;
    int             cyc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  logic rst_at_edge = 1'b0;
  exp_t q[$];

  shift_add_mult #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: plain integer multiplication; completion expected
  // WIDTH+1 cycles after the cycle in which start is accepted.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e.prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    e.cyc  = cyc + W + 1;
    start = 1'b1;
    a = x;
    b = y;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_within_bound", {63'b0, seen}, 64'd1);
  endtask

  // Monitor / scoreboard
  initial begin
    logic armed;
    int   run_len;
    logic [2*W-1:0] held;
    exp_t e;
    armed   = 1'b0;
    run_len = 0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (rst_at_edge) begin
        armed = 1'b1;
        chk("reset_busy", {63'b0, busy}, 64'd0);
        chk("reset_done", {63'b0, done}, 64'd0);
        chk("reset_product", {32'b0, product}, 64'd0);
        held    = '0;
        run_len = 0;
        q.delete();
      end else if (armed) begin
        chk("busy_done_exclusive", {63'b0, busy & done}, 64'd0);
        if (done) begin
          chk("busy_run_length", 64'(run_len), 64'(W));
          run_len = 0;
          if (q.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
          end else begin
            e = q.pop_front();
            chk("product", {32'b0, product}, {32'b0, e.prod});
            chk("done_cycle", 64'(cyc), 64'(e.cyc));
            held = e.prod;
          end
        end else begin
          chk("product_held", {32'b0, product}, {32'b0, held});
          if (busy) run_len++;
          else run_len = 0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] x, y;
    int gap;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    start_op(16'h0003, 16'h0005); wait_done(); @(negedge clk);
    start_op(16'hFFFF, 16'hFFFF); wait_done(); @(negedge clk);
    start_op(16'h0000, 16'hBEEF); wait_done();
    start_op(16'h1234, 16'h0010); wait_done(); repeat (2) @(negedge clk);

    // start pulse during RUN cycle 5 must be ignored
    start_op(16'h0002, 16'h0003);
    repeat (4) @(negedge clk);
    start = 1'b1; a = 16'h7777; b = 16'h7777;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (20) @(negedge clk);

    // back-to-back: start in the DONE cycle
    start_op(16'h0005, 16'h0007); wait_done();
    start_op(16'h0100, 16'h0100); wait_done();
    repeat (2) @(negedge clk);

    // reset during RUN cycle 8
    start_op(16'h00FF, 16'h00FF);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: x = 16'hFFFF;
        1: x = 16'h8000;
        default: x = W'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0: y = 16'hFFFF;
        1: y = 16'h0001;
        default: y = W'($urandom);
      endcase
      start_op(x, y);
      wait_done();
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
    end

    repeat (30) @(negedge clk);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
